sha3_256_absorb: RTL and testbench

Sequential sponge-absorb front end for the SHA3-256 datapath. It accepts the message as 64-bit little-endian words over a valid/ready stream and XORs each word into the rate portion of the 1600-bit Keccak state. It applies SHA3 multi-rate padding, hands each full block to the Keccak-f[1600] permutation core (the theta/rho/pi/chi/iota rounds) over a start/done handshake, and presents the absorbed state to the squeeze stage. It is the producer of the state word that the theta step consumes.

---
 rtl/sha3_256_absorb_if.sv | 25 ++
 rtl/sha3_256_absorb.sv | 164 ++++++++++++++++
 tb/tb_sha3_256_absorb.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha3_256_absorb_if.sv
// Message word stream into the SHA3-256 absorb stage: 64-bit little-endian words
// with a last flag and a valid-byte count for the final word.
interface sha3_256_absorb_if;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic [3:0]  in_bytes;
    logic        in_ready;

    modport master (
        output in_data,
        output in_valid,
        output in_last,
        output in_bytes,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_last,
        input  in_bytes,
        output in_ready
    );
endinterface

// File: rtl/sha3_256_absorb.sv
// SHA3-256 sponge absorb front end: XORs message words into the rate lanes, pads, and
// sequences Keccak-f permutations. Define SHA3_KECCAK_PAD_EN for original Keccak padding.
module sha3_256_absorb #(
    parameter int RATE_LANES = 17
) (
    input  logic                clk,
    input  logic                rst,
    sha3_256_absorb_if.slave    msg,
    output logic                perm_start,
    output logic [1599:0]       perm_state_in,
    input  logic [1599:0]       perm_state_out,
    input  logic                perm_done,
    output logic [1599:0]       state_out,
    output logic                state_valid,
    input  logic                state_ack
);

    localparam int KW = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(RATE_LANES - 1);

`ifdef SHA3_KECCAK_PAD_EN
    localparam logic [7:0] PADB = 8'h01;
`else
    localparam logic [7:0] PADB = 8'h06;
`endif

    typedef enum logic [1:0] {
        ABSORB,
        PAD,
        PERM,
        DONE
    } fsm_t;

    fsm_t            fsm_reg;
    logic [1599:0]   s_reg;
    logic [KW-1:0]   k_reg;
    logic            final_reg;
    logic            pad_pending_reg;
    logic            perm_start_reg;
    logic            state_valid_reg;
    logic            in_ready_reg;

    logic            accept;
    logic [3:0]      n_eff;
    logic            full_last;
    logic            spill_ok;
    logic            closes_msg;
    logic [KW-1:0]   k_plus;
    logic [63:0]     last_word;
    logic [63:0]     word_k;
    logic [1599:0]   absorb_xor;
    logic [1599:0]   pad_xor;

    assign msg.in_ready  = in_ready_reg & ~rst;
    assign accept        = msg.in_valid & msg.in_ready;
    assign n_eff         = (msg.in_bytes > 4'd8) ? 4'd8 : msg.in_bytes;
    assign k_plus        = k_reg + 1'b1;

    // A full final word pushes the domain byte into the next lane, or into a
    // padding-only block when the word already filled the last rate lane.
    assign full_last     = msg.in_last && (n_eff == 4'd8);
    assign spill_ok      = full_last && (k_reg != K_LAST);
    assign closes_msg    = msg.in_last && !(full_last && (k_reg == K_LAST));

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_byte
            assign last_word[8*gi +: 8] = (4'(gi) < n_eff)  ? msg.in_data[8*gi +: 8] :
                                          (4'(gi) == n_eff) ? PADB : 8'h00;
        end
    endgenerate

    assign word_k = msg.in_last ? last_word : msg.in_data;

    generate
        for (genvar gi = 0; gi < 25; gi++) begin : g_lane
            assign pad_xor[64*gi +: 64] = {((gi == RATE_LANES - 1) ? 8'h80 : 8'h00),
                                           48'd0,
                                           ((gi == 0) ? PADB : 8'h00)};
            if (gi < RATE_LANES) begin : g_rate
                logic [63:0] lane_word;
                logic [63:0] lane_spill;
                logic [63:0] lane_end;
                assign lane_word  = (k_reg == KW'(gi)) ? word_k : 64'd0;
                assign lane_spill = (spill_ok && (k_plus == KW'(gi))) ? {56'd0, PADB} : 64'd0;
                assign lane_end   = ((gi == RATE_LANES - 1) && closes_msg) ? {8'h80, 56'd0} : 64'd0;
                assign absorb_xor[64*gi +: 64] = lane_word ^ lane_spill ^ lane_end;
            end else begin : g_capacity
                assign absorb_xor[64*gi +: 64] = 64'd0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_reg         <= ABSORB;
            s_reg           <= '0;
            k_reg           <= '0;
            final_reg       <= 1'b0;
            pad_pending_reg <= 1'b0;
            perm_start_reg  <= 1'b0;
            state_valid_reg <= 1'b0;
            in_ready_reg    <= 1'b1;
        end else begin
            perm_start_reg <= 1'b0;
            case (fsm_reg)
                ABSORB: begin
                    if (accept) begin
                        s_reg <= s_reg ^ absorb_xor;
                        if (!msg.in_last && (k_reg != K_LAST)) begin
                            k_reg <= k_plus;
                        end else begin
                            fsm_reg         <= PERM;
                            perm_start_reg  <= 1'b1;
                            in_ready_reg    <= 1'b0;
                            final_reg       <= closes_msg;
                            pad_pending_reg <= full_last && (k_reg == K_LAST);
                        end
                    end
                end
                PERM: begin
                    // A done coincident with our own start pulse belongs to nobody.
                    if (perm_done && !perm_start_reg) begin
                        s_reg <= perm_state_out;
                        k_reg <= '0;
                        if (final_reg) begin
                            fsm_reg         <= DONE;
                            state_valid_reg <= 1'b1;
                        end else if (pad_pending_reg) begin
                            pad_pending_reg <= 1'b0;
                            fsm_reg         <= PAD;
                        end else begin
                            fsm_reg      <= ABSORB;
                            in_ready_reg <= 1'b1;
                        end
                    end
                end
                PAD: begin
                    s_reg          <= s_reg ^ pad_xor;
                    final_reg      <= 1'b1;
                    fsm_reg        <= PERM;
                    perm_start_reg <= 1'b1;
                end
                DONE: begin
                    if (state_ack) begin
                        s_reg           <= '0;
                        final_reg       <= 1'b0;
                        state_valid_reg <= 1'b0;
                        fsm_reg         <= ABSORB;
                        in_ready_reg    <= 1'b1;
                    end
                end
                default: begin
                    fsm_reg <= ABSORB;
                end
            endcase
        end
    end

    assign perm_start    = perm_start_reg;
    assign perm_state_in = s_reg;
    assign state_out     = s_reg;
    assign state_valid   = state_valid_reg;

endmodule

// File: tb/tb_sha3_256_absorb.sv
// Bench for sha3_256_absorb: byte-level sponge reference model, keyed stub permutation
// (state XOR key, done 3 cycles after start), directed and randomized messages.
module tb_sha3_256_absorb;

    localparam int R  = 17;
    localparam int RB = R * 8;

`ifdef SHA3_KECCAK_PAD_EN
    localparam logic [7:0]  PADB      = 8'h01;
    localparam logic [63:0] ABC_LANE0 = 64'h0000_0000_0163_6261;
`else
    localparam logic [7:0]  PADB      = 8'h06;
    localparam logic [63:0] ABC_LANE0 = 64'h0000_0000_0663_6261;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          perm_start;
    logic [1599:0] perm_state_in;
    logic [1599:0] perm_state_out = '0;
    logic          perm_done = 1'b0;
    logic [1599:0] state_out;
    logic          state_valid;
    logic          state_ack;

    sha3_256_absorb_if m();

    sha3_256_absorb #(.RATE_LANES(R)) dut (
        .clk            (clk),
        .rst            (rst),
        .msg            (m),
        .perm_start     (perm_start),
        .perm_state_in  (perm_state_in),
        .perm_state_out (perm_state_out),
        .perm_done      (perm_done),
        .state_out      (state_out),
        .state_valid    (state_valid),
        .state_ack      (state_ack)
    );

    always #5 clk = ~clk;

    // Stub core: ignores rst on purpose so a stale done can reach the DUT after an abort.
    logic [1:0]    stub_cnt = 2'd0;
    logic [1599:0] stub_key = '0;
    always @(posedge clk) begin
        perm_done <= 1'b0;
        if (perm_start) begin
            stub_cnt       <= 2'd2;
            perm_state_out <= perm_state_in ^ stub_key;
        end else if (stub_cnt != 2'd0) begin
            stub_cnt <= stub_cnt - 2'd1;
            if (stub_cnt == 2'd1) perm_done <= 1'b1;
        end
    end

    int            cyc = 0;
    int            done_cyc = 0;
    int            rise_cyc = 0;
    logic          prev_valid = 1'b0;
    logic [1599:0] starts_q[$];
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (perm_start === 1'b1) starts_q.push_back(perm_state_in);
        if (perm_done === 1'b1) done_cyc = cyc;
        if (state_valid === 1'b1 && !prev_valid) rise_cyc = cyc;
        prev_valid = (state_valid === 1'b1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500000 time units");
        $fatal(1);
    end

    int            total = 0;
    int            bad = 0;
    logic [7:0]    msg_q[$];
    logic [1599:0] exp_q[$];
    logic [1599:0] exp_final;

    function automatic int diff_lane(input logic [1599:0] a, input logic [1599:0] b);
        for (int i = 0; i < 25; i++) if (a[64*i +: 64] !== b[64*i +: 64]) return i;
        return 0;
    endfunction

    // Sponge over whole padded blocks, computed on bytes rather than lanes.
    task automatic model();
        logic [7:0]    p[$];
        logic [1599:0] s;
        p = msg_q;
        p.push_back(PADB);
        while (p.size() % RB != 0) p.push_back(8'h00);
        p[p.size() - 1] = p[p.size() - 1] ^ 8'h80;
        s = '0;
        exp_q.delete();
        for (int b = 0; b < p.size() / RB; b++) begin
            for (int i = 0; i < RB; i++) s[8*i +: 8] = s[8*i +: 8] ^ p[b*RB + i];
            exp_q.push_back(s);
            s = s ^ stub_key;
        end
        exp_final = s;
    endtask

    task automatic rand_key();
        for (int i = 0; i < 50; i++) stub_key[32*i +: 32] = $urandom;
    endtask

    task automatic rand_msg(input int len);
        msg_q.delete();
        for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
    endtask

    task automatic send_word(input logic [63:0] d, input bit last, input logic [3:0] nb,
                             output int stalls);
        bit hs;
        m.in_data  = d;
        m.in_last  = last;
        m.in_bytes = nb;
        m.in_valid = 1'b1;
        stalls = 0;
        forever begin
            hs = (m.in_ready === 1'b1);
            @(negedge clk);
            if (hs) break;
            stalls++;
            if (stalls > 100) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: got in_ready=0 want 1 within 100 cycles");
                break;
            end
        end
        m.in_valid = 1'b0;
    endtask

    task automatic send_msg(input bit junk_ff, input int gap_max);
        int          nw;
        int          n;
        int          st;
        bit          last;
        logic [3:0]  nb;
        logic [63:0] d;
        nw = (msg_q.size() == 0) ? 1 : (msg_q.size() + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            n = msg_q.size() - 8*w;
            if (n > 8) n = 8;
            for (int j = 0; j < 8; j++)
                d[8*j +: 8] = (j < n) ? msg_q[8*w + j] : (junk_ff ? 8'hFF : 8'($urandom));
            last = (w == nw - 1);
            nb = last ? 4'(n) : 4'($urandom);
            if (last && n == 8 && $urandom_range(0, 1) == 1) nb = 4'($urandom_range(8, 15));
            send_word(d, last, nb, st);
            m.in_data = {$urandom, $urandom};
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (state_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_ack();
        state_ack = 1'b1;
        @(negedge clk);
        state_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        state_ack = 1'b0;
        m.in_valid = 1'b0;
        m.in_last = 1'b0;
        m.in_bytes = 4'd0;
        m.in_data = '0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (m.in_ready !== 1'b0) begin
            bad++; $display("FAIL reset_in_ready: got %b want 0", m.in_ready);
        end
        total++;
        if (perm_start !== 1'b0 || state_valid !== 1'b0) begin
            bad++; $display("FAIL reset_ctrl: got start=%b valid=%b want 0 0", perm_start, state_valid);
        end
        total++;
        if (state_out !== '0) begin
            bad++; $display("FAIL reset_state: got lane%0d=%h want 0",
                            diff_lane(state_out, '0), state_out[64*diff_lane(state_out, '0) +: 64]);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (m.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release_ready: got %b want 1", m.in_ready);
        end
        $display("reset: done");
    endtask

    task automatic test_empty();
        int            base;
        bit            ok;
        logic [1599:0] ev;
        stub_key = '0;
        msg_q.delete();
        base = starts_q.size();
        send_msg(1'b1, 0);
        wait_valid(ok);
        ev = '0;
        ev[7:0] = PADB;
        ev[64*(R-1) + 56 +: 8] = 8'h80;
        total++;
        if (!ok) begin bad++; $display("FAIL empty_valid: got state_valid=0 want 1"); end
        total++;
        if (starts_q.size() - base != 1) begin
            bad++; $display("FAIL empty_starts: got %0d want 1", starts_q.size() - base);
        end else begin
            total++;
            if (starts_q[base] !== ev) begin
                bad++; $display("FAIL empty_perm_in lane%0d: got %h want %h", diff_lane(starts_q[base], ev),
                                starts_q[base][64*diff_lane(starts_q[base], ev) +: 64],
                                ev[64*diff_lane(starts_q[base], ev) +: 64]);
            end
        end
        total++;
        if (rise_cyc - done_cyc != 1) begin
            bad++; $display("FAIL empty_latency: got %0d want 1", rise_cyc - done_cyc);
        end
        do_ack();
        total++;
        if (state_valid !== 1'b0 || state_out !== '0 || m.in_ready !== 1'b1) begin
            bad++; $display("FAIL empty_ack: got valid=%b ready=%b state_zero=%b want 0 1 1",
                            state_valid, m.in_ready, state_out == '0);
        end
        $display("empty: blocks=%0d", starts_q.size() - base);
    endtask

    task automatic test_abc();
        int base;
        bit ok;
        rand_key();
        do_ack();
        msg_q = '{8'h61, 8'h62, 8'h63};
        model();
        base = starts_q.size();
        send_msg(1'b0, 0);
        wait_valid(ok);
        total++;
        if (!ok || starts_q.size() - base != 1) begin
            bad++; $display("FAIL abc_starts: got %0d valid=%b want 1 1", starts_q.size() - base, ok);
        end else begin
            total++;
            if (starts_q[base][63:0] !== ABC_LANE0) begin
                bad++; $display("FAIL abc_lane0: got %h want %h", starts_q[base][63:0], ABC_LANE0);
            end
        end
        total++;
        if (state_out !== exp_final) begin
            bad++; $display("FAIL abc_state_out lane%0d: got %h want %h", diff_lane(state_out, exp_final),
                            state_out[64*diff_lane(state_out, exp_final) +: 64],
                            exp_final[64*diff_lane(state_out, exp_final) +: 64]);
        end
        do_ack();
        $display("abc: blocks=%0d", starts_q.size() - base);
    endtask

    task automatic test_135();
        int base;
        bit ok;
        rand_key();
        rand_msg(135);
        model();
        base = starts_q.size();
        send_msg(1'b0, 2);
        wait_valid(ok);
        total++;
        if (!ok || starts_q.size() - base != 1) begin
            bad++; $display("FAIL b135_starts: got %0d valid=%b want 1 1", starts_q.size() - base, ok);
        end else begin
            total++;
            if (starts_q[base][64*16 + 56 +: 8] !== (PADB ^ 8'h80)) begin
                bad++; $display("FAIL b135_lane16_byte7: got %h want %h",
                                starts_q[base][64*16 + 56 +: 8], PADB ^ 8'h80);
            end
            total++;
            if (starts_q[base] !== exp_q[0]) begin
                bad++; $display("FAIL b135_perm_in lane%0d: got %h want %h", diff_lane(starts_q[base], exp_q[0]),
                                starts_q[base][64*diff_lane(starts_q[base], exp_q[0]) +: 64],
                                exp_q[0][64*diff_lane(starts_q[base], exp_q[0]) +: 64]);
            end
        end
        do_ack();
        $display("len135: blocks=%0d", starts_q.size() - base);
    endtask

    task automatic test_136();
        int base;
        bit ok;
        rand_key();
        rand_msg(136);
        model();
        base = starts_q.size();
        send_msg(1'b0, 1);
        wait_valid(ok);
        total++;
        if (!ok || starts_q.size() - base != 2) begin
            bad++; $display("FAIL b136_starts: got %0d valid=%b want 2 1", starts_q.size() - base, ok);
        end else begin
            for (int i = 0; i < 2; i++) begin
                total++;
                if (starts_q[base+i] !== exp_q[i]) begin
                    bad++; $display("FAIL b136_perm_in%0d lane%0d: got %h want %h", i,
                                    diff_lane(starts_q[base+i], exp_q[i]),
                                    starts_q[base+i][64*diff_lane(starts_q[base+i], exp_q[i]) +: 64],
                                    exp_q[i][64*diff_lane(starts_q[base+i], exp_q[i]) +: 64]);
                end
            end
        end
        total++;
        if (state_out !== exp_final) begin
            bad++; $display("FAIL b136_state_out lane%0d: got %h want %h", diff_lane(state_out, exp_final),
                            state_out[64*diff_lane(state_out, exp_final) +: 64],
                            exp_final[64*diff_lane(state_out, exp_final) +: 64]);
        end
        do_ack();
        $display("len136: blocks=%0d", starts_q.size() - base);
    endtask

    task automatic test_backpressure();
        int          base;
        int          st;
        bit          ok;
        logic [63:0] d;
        rand_key();
        rand_msg(160);
        model();
        base = starts_q.size();
        for (int w = 0; w < 20; w++) begin
            for (int j = 0; j < 8; j++) d[8*j +: 8] = msg_q[8*w + j];
            send_word(d, w == 19, 4'd8, st);
            if (w == 17) begin
                total++;
                if (st != 4) begin
                    bad++; $display("FAIL bp_stall_cycles: got %0d want 4", st);
                end
            end
        end
        wait_valid(ok);
        total++;
        if (!ok || starts_q.size() - base != exp_q.size()) begin
            bad++; $display("FAIL bp_starts: got %0d valid=%b want %0d 1", starts_q.size() - base, ok, exp_q.size());
        end
        total++;
        if (state_out !== exp_final) begin
            bad++; $display("FAIL bp_state_out lane%0d: got %h want %h", diff_lane(state_out, exp_final),
                            state_out[64*diff_lane(state_out, exp_final) +: 64],
                            exp_final[64*diff_lane(state_out, exp_final) +: 64]);
        end
        do_ack();
        $display("backpressure: words=20 blocks=%0d", starts_q.size() - base);
    endtask

    task automatic test_reset_mid_perm();
        int          st;
        int          cnt;
        int          base;
        bit          ok;
        rand_key();
        for (int w = 0; w < R; w++) send_word({$urandom, $urandom}, 1'b0, 4'd0, st);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (m.in_ready !== 1'b0 || state_out !== '0) begin
            bad++; $display("FAIL rstperm_during: got ready=%b state_zero=%b want 0 1", m.in_ready, state_out == '0);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (m.in_ready !== 1'b1) begin
            bad++; $display("FAIL rstperm_ready: got %b want 1", m.in_ready);
        end
        cnt = starts_q.size();
        repeat (6) @(negedge clk);
        total++;
        if (starts_q.size() != cnt || state_out !== '0 || state_valid !== 1'b0) begin
            bad++; $display("FAIL rstperm_quiet: got starts=%0d state_zero=%b valid=%b want 0 1 0",
                            starts_q.size() - cnt, state_out == '0, state_valid);
        end
        msg_q = '{8'h61, 8'h62, 8'h63};
        model();
        base = starts_q.size();
        send_msg(1'b0, 0);
        wait_valid(ok);
        total++;
        if (!ok || starts_q.size() - base != 1 || state_out !== exp_final) begin
            bad++; $display("FAIL rstperm_after: got starts=%0d valid=%b lane0=%h want 1 1 %h",
                            starts_q.size() - base, ok, state_out[63:0], exp_final[63:0]);
        end
        do_ack();
        $display("reset_mid_perm: done");
    endtask

    task automatic test_random();
        int base;
        int len;
        bit ok;
        for (int it = 0; it < 8; it++) begin
            rand_key();
            len = $urandom_range(0, 300);
            rand_msg(len);
            model();
            base = starts_q.size();
            send_msg(1'b0, 3);
            wait_valid(ok);
            total++;
            if (!ok || starts_q.size() - base != exp_q.size()) begin
                bad++; $display("FAIL rnd%0d_starts: got %0d valid=%b want %0d 1", it,
                                starts_q.size() - base, ok, exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    total++;
                    if (starts_q[base+i] !== exp_q[i]) begin
                        bad++; $display("FAIL rnd%0d_perm_in%0d lane%0d: got %h want %h", it, i,
                                        diff_lane(starts_q[base+i], exp_q[i]),
                                        starts_q[base+i][64*diff_lane(starts_q[base+i], exp_q[i]) +: 64],
                                        exp_q[i][64*diff_lane(starts_q[base+i], exp_q[i]) +: 64]);
                    end
                end
            end
            total++;
            if (state_out !== exp_final) begin
                bad++; $display("FAIL rnd%0d_state_out lane%0d: got %h want %h", it, diff_lane(state_out, exp_final),
                                state_out[64*diff_lane(state_out, exp_final) +: 64],
                                exp_final[64*diff_lane(state_out, exp_final) +: 64]);
            end
            total++;
            if (rise_cyc - done_cyc != 1) begin
                bad++; $display("FAIL rnd%0d_latency: got %0d want 1", it, rise_cyc - done_cyc);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_ack();
            $display("random msg %0d: len=%0d blocks=%0d", it, len, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_abc();
        test_135();
        test_136();
        test_backpressure();
        test_reset_mid_perm();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
